// File: rtl/alu_pkg.sv
// Shared definitions for the alu_core block: operand width default and the
// sixteen opcode encodings used by the datapath and by anything driving it.
package alu_pkg;

    // Operand width used when a parent does not override it.
    localparam int DEFAULT_WIDTH = 8;

    // Opcode encodings. All sixteen codes are defined, so there is no
    // illegal-opcode handling anywhere in the block.
    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_MUL  = 4'b0010;
    localparam logic [3:0] OP_DIV  = 4'b0011;
    localparam logic [3:0] OP_SHL  = 4'b0100;
    localparam logic [3:0] OP_SHR  = 4'b0101;
    localparam logic [3:0] OP_ROL  = 4'b0110;
    localparam logic [3:0] OP_ROR  = 4'b0111;
    localparam logic [3:0] OP_AND  = 4'b1000;
    localparam logic [3:0] OP_OR   = 4'b1001;
    localparam logic [3:0] OP_XOR  = 4'b1010;
    localparam logic [3:0] OP_NOR  = 4'b1011;
    localparam logic [3:0] OP_NAND = 4'b1100;
    localparam logic [3:0] OP_XNOR = 4'b1101;
    localparam logic [3:0] OP_GT   = 4'b1110;
    localparam logic [3:0] OP_EQ   = 4'b1111;

endpackage

// File: rtl/alu_core_if.sv
// Operand/opcode/result bundle between a datapath master and the ALU.
// The master presents A, B and ALU_Sel every cycle and reads the registered
// ALU_Result one cycle later; there is no handshake.
interface alu_core_if
    import alu_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) ();

    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [3:0]       ALU_Sel;
    logic [WIDTH:0]   ALU_Result;

    modport master (
        output A,
        output B,
        output ALU_Sel,
        input  ALU_Result
    );

    modport slave (
        input  A,
        input  B,
        input  ALU_Sel,
        output ALU_Result
    );

endinterface

// File: rtl/alu_datapath.sv
// Purely combinational ALU function: selects one of sixteen unsigned
// operations on a and b and produces the WIDTH+1 bit next result. The top
// bit carries carry, borrow or shifted-out MSB where the operation has one.
module alu_datapath
    import alu_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       sel,
    output logic [WIDTH:0]   result
);

    // Zero-extended operands so arithmetic naturally lands in WIDTH+1 bits:
    // the add carry and the subtract borrow fall into the top bit, and the
    // multiply truncates to the low WIDTH+1 bits of the full product.
    logic [WIDTH:0] a_ext;
    logic [WIDTH:0] b_ext;
    logic           divide_by_zero;

    assign a_ext          = {1'b0, a};
    assign b_ext          = {1'b0, b};
    assign divide_by_zero = (b == '0);

    // Opcode decode producing the next registered result.
    always_comb begin
        result = '0;
        case (sel)
            OP_ADD:  result = a_ext + b_ext;
            OP_SUB:  result = a_ext - b_ext;
            OP_MUL:  result = a_ext * b_ext;
            OP_DIV:  result = divide_by_zero ? '1 : {1'b0, a / b};
            OP_SHL:  result = {a, 1'b0};
            OP_SHR:  result = {2'b00, a[WIDTH-1:1]};
            OP_ROL:  result = {1'b0, a[WIDTH-2:0], a[WIDTH-1]};
            OP_ROR:  result = {1'b0, a[0], a[WIDTH-1:1]};
            OP_AND:  result = {1'b0, a & b};
            OP_OR:   result = {1'b0, a | b};
            OP_XOR:  result = {1'b0, a ^ b};
            OP_NOR:  result = {1'b0, ~(a | b)};
            OP_NAND: result = {1'b0, ~(a & b)};
            OP_XNOR: result = {1'b0, ~(a ^ b)};
            OP_GT:   result = {{WIDTH{1'b0}}, (a > b)};
            OP_EQ:   result = {{WIDTH{1'b0}}, (a == b)};
        endcase
    end

endmodule

// File: rtl/alu_core.sv
// Leaf arithmetic/logic unit for the datapath. Operands and opcode are
// sampled on every rising clock edge and the WIDTH+1 bit result is presented
// one cycle later. An asynchronous active-low reset clears the result at once.
module alu_core
    import alu_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic       clk,
    input  logic       rst_n,
    alu_core_if.slave  bus
);

    logic [WIDTH:0] next_result;
    logic [WIDTH:0] result_q;

    alu_datapath #(
        .WIDTH (WIDTH)
    ) u_datapath (
        .a      (bus.A),
        .b      (bus.B),
        .sel    (bus.ALU_Sel),
        .result (next_result)
    );

    // Output register: loads the datapath result each edge, cleared
    // immediately whenever reset is asserted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result_q <= '0;
        end else begin
            result_q <= next_result;
        end
    end

    assign bus.ALU_Result = result_q;

endmodule

// File: tb/tb_alu_core.sv
// Directed testbench for alu_core. Inputs change on the falling edge, the
// DUT samples them on the rising edge, and outputs are checked 1 ns later.
module tb_alu_core;
    import alu_pkg::*;

    logic clk;
    logic rst_n;

    int checks;
    int failures;

    alu_core_if #(.WIDTH(8)) bus ();

    alu_core #(
        .WIDTH (8)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    // Free-running 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Present one operation at the falling edge, then step past the next
    // rising edge so the registered result can be observed.
    task automatic apply(input logic [7:0] a, input logic [7:0] b, input logic [3:0] sel);
        @(negedge clk);
        bus.A       = a;
        bus.B       = b;
        bus.ALU_Sel = sel;
        @(posedge clk);
        #1;
    endtask

    // Vector packing: {a[28:21], b[20:13], sel[12:9], expected[8:0]}.
    task automatic run_vectors(input string label, input logic [28:0] vecs [], input int count);
        for (int i = 0; i < count; i++) begin
            apply(vecs[i][28:21], vecs[i][20:13], vecs[i][12:9]);
            checks++;
            if (bus.ALU_Result !== vecs[i][8:0]) begin
                failures++;
                $display("[TB] FAIL %s[%0d] a=%h b=%h sel=%b got=%h expected=%h",
                         label, i, vecs[i][28:21], vecs[i][20:13], vecs[i][12:9],
                         bus.ALU_Result, vecs[i][8:0]);
            end
        end
    endtask

    task automatic test_reset();
        rst_n       = 1'b0;
        bus.A       = 8'hFF;
        bus.B       = 8'hFF;
        bus.ALU_Sel = OP_ADD;
        #2;
        checks++;
        if (bus.ALU_Result !== 9'h000) begin
            failures++;
            $display("[TB] FAIL reset_initial got=%h expected=%h", bus.ALU_Result, 9'h000);
        end
        @(posedge clk);
        #1;
        checks++;
        if (bus.ALU_Result !== 9'h000) begin
            failures++;
            $display("[TB] FAIL reset_held_over_edge got=%h expected=%h", bus.ALU_Result, 9'h000);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++;
        if (bus.ALU_Result !== 9'h000) begin
            failures++;
            $display("[TB] FAIL reset_release_no_edge got=%h expected=%h", bus.ALU_Result, 9'h000);
        end
    endtask

    task automatic test_add();
        logic [28:0] v [] = '{
            {8'hFF, 8'h00, OP_ADD, 9'h0FF},
            {8'hF0, 8'h0F, OP_ADD, 9'h0FF},
            {8'hFF, 8'hFF, OP_ADD, 9'h1FE}
        };
        run_vectors("add", v, 3);
    endtask

    task automatic test_sub();
        logic [28:0] v [] = '{
            {8'h05, 8'h0A, OP_SUB, 9'h1FB},
            {8'h0A, 8'h05, OP_SUB, 9'h005},
            {8'h42, 8'h42, OP_SUB, 9'h000}
        };
        run_vectors("sub", v, 3);
    endtask

    task automatic test_mul_div();
        logic [28:0] v [] = '{
            {8'h10, 8'h20, OP_MUL, 9'h000},
            {8'h0F, 8'h11, OP_MUL, 9'h0FF},
            {8'h13, 8'h1B, OP_MUL, 9'h001},
            {8'd200, 8'd7, OP_DIV, 9'd28},
            {8'h33, 8'h00, OP_DIV, 9'h1FF},
            {8'h05, 8'h09, OP_DIV, 9'h000}
        };
        run_vectors("muldiv", v, 6);
    endtask

    task automatic test_shift_rotate();
        logic [28:0] v [] = '{
            {8'h81, 8'h00, OP_SHL, 9'h102},
            {8'h81, 8'h00, OP_SHR, 9'h040},
            {8'h81, 8'h00, OP_ROL, 9'h003},
            {8'h81, 8'h00, OP_ROR, 9'h0C0},
            {8'h4E, 8'h00, OP_ROL, 9'h09C},
            {8'h4E, 8'h00, OP_ROR, 9'h027}
        };
        run_vectors("shift", v, 6);
    endtask

    task automatic test_logic_compare();
        logic [28:0] v [] = '{
            {8'hF0, 8'h3C, OP_AND,  9'h030},
            {8'hF0, 8'h3C, OP_OR,   9'h0FC},
            {8'hF0, 8'h3C, OP_XOR,  9'h0CC},
            {8'hF0, 8'h3C, OP_NOR,  9'h003},
            {8'hF0, 8'h3C, OP_NAND, 9'h0CF},
            {8'hF0, 8'h3C, OP_XNOR, 9'h033},
            {8'hF0, 8'h3C, OP_GT,   9'h001},
            {8'hF0, 8'h3C, OP_EQ,   9'h000},
            {8'h3C, 8'h3C, OP_EQ,   9'h001},
            {8'h3C, 8'h3C, OP_GT,   9'h000},
            {8'h3C, 8'hF0, OP_GT,   9'h000}
        };
        run_vectors("logic", v, 11);
    endtask

    task automatic test_latency_hold();
        apply(8'hFF, 8'hFF, OP_ADD);
        @(negedge clk);
        bus.A       = 8'h00;
        bus.B       = 8'h00;
        bus.ALU_Sel = OP_EQ;
        #1;
        checks++;
        if (bus.ALU_Result !== 9'h1FE) begin
            failures++;
            $display("[TB] FAIL hold_before_edge got=%h expected=%h", bus.ALU_Result, 9'h1FE);
        end
        @(posedge clk);
        #1;
        checks++;
        if (bus.ALU_Result !== 9'h001) begin
            failures++;
            $display("[TB] FAIL load_after_edge got=%h expected=%h", bus.ALU_Result, 9'h001);
        end
    endtask

    task automatic test_back_to_back();
        logic [28:0] v [] = '{
            {8'h01, 8'h02, OP_ADD, 9'h003},
            {8'h01, 8'h02, OP_SUB, 9'h1FF},
            {8'h07, 8'h09, OP_MUL, 9'h03F},
            {8'hC8, 8'h0A, OP_DIV, 9'h014},
            {8'hAA, 8'h55, OP_XOR, 9'h0FF},
            {8'hAA, 8'h55, OP_AND, 9'h000}
        };
        run_vectors("b2b", v, 6);
    endtask

    task automatic test_reset_midstream();
        apply(8'hFF, 8'hFF, OP_ADD);
        checks++;
        if (bus.ALU_Result !== 9'h1FE) begin
            failures++;
            $display("[TB] FAIL midreset_preload got=%h expected=%h", bus.ALU_Result, 9'h1FE);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.ALU_Result !== 9'h000) begin
            failures++;
            $display("[TB] FAIL midreset_async_clear got=%h expected=%h", bus.ALU_Result, 9'h000);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++;
        if (bus.ALU_Result !== 9'h000) begin
            failures++;
            $display("[TB] FAIL midreset_release_no_edge got=%h expected=%h", bus.ALU_Result, 9'h000);
        end
        @(posedge clk);
        #1;
        checks++;
        if (bus.ALU_Result !== 9'h1FE) begin
            failures++;
            $display("[TB] FAIL midreset_first_edge got=%h expected=%h", bus.ALU_Result, 9'h1FE);
        end
    endtask

    // Scenario sequence followed by the single summary line.
    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_add();
        test_sub();
        test_mul_div();
        test_shift_rotate();
        test_logic_compare();
        test_latency_hold();
        test_back_to_back();
        test_reset_midstream();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
